// File: rtl/cpu_pkg.sv
//==============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and defaults for the 8-bit mini CPU sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int c_rom_size  = 8;
    localparam int c_word_size = 8;

    typedef logic [c_word_size-1:0] word_t;

    typedef enum logic [1:0] {
        ALU_MOV = 2'd0,
        ALU_ADD = 2'd1,
        ALU_XOR = 2'd2,
        ALU_AND = 2'd3
    } alu_op_t;

    // V0/V1 are read-only constants; writes to them are discarded.
    typedef enum logic [2:0] {
        REG_RA = 3'd0,
        REG_R0 = 3'd1,
        REG_R1 = 3'd2,
        REG_R2 = 3'd3,
        REG_P0 = 3'd4,
        REG_P1 = 3'd5,
        REG_V0 = 3'd6,
        REG_V1 = 3'd7
    } register_name_t;

    typedef struct packed {
        logic if_flag;
        logic if_not_flag;
        logic set_flag;
    } exec_opts_t;

    typedef struct packed {
        exec_opts_t     exec;
        alu_op_t        op;
        register_name_t r;
        register_name_t write_to;
    } instruction_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } cpu_seq_state_t;

    function automatic logic is_const_reg(input register_name_t name);
        return (name == REG_V0) || (name == REG_V1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_cond_eval.sv
//==============================================================================
// Module   : cpu_cond_eval
// Brief    : Combinational skip decision from exec options and condition flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_cond_eval
    import cpu_pkg::*;
(
    input  exec_opts_t exec,
    input  logic       flag,
    output logic       skip
);

    // Both qualifiers set can never be satisfied, so it always skips.
    assign skip = (exec.if_flag && !flag) || (exec.if_not_flag && flag);

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
//==============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle FETCH/READ/EXEC/WB control FSM for the mini CPU.
//            Optional CPU_SEQ_STEP_EN adds a single-step input gating FETCH.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter  int ROM_SIZE  = c_rom_size,
    parameter  int WORD_SIZE = c_word_size,
    localparam int PCW       = $clog2(ROM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CPU_SEQ_STEP_EN
    input  logic                 step,
`endif
    output logic [PCW-1:0]       rom_addr,
    input  logic [10:0]          rom_data,
    output logic [2:0]           rd_sel,
    output logic                 rd_en,
    input  logic                 rd_ready,
    output logic [1:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_flag,
    output logic [2:0]           wr_sel,
    output logic                 wr_en,
    input  logic                 wr_done,
    output logic                 flag,
    output logic [WORD_SIZE-1:0] retired
);

    cpu_seq_state_t       r_state;
    cpu_seq_state_t       w_next_state;
    logic [PCW-1:0]       r_pc;
    instruction_t         r_ir;
    logic                 r_flag;
    logic                 r_wb_first;
    logic [WORD_SIZE-1:0] r_retired;

    instruction_t w_instr;
    logic         w_skip;
    logic         w_go;
    logic         w_const_dst;
    logic         w_wb_done;
    logic         w_pc_adv;
    logic         w_ir_load;
    logic         w_retire;
    logic         w_flag_load;
    logic         w_unused_exec;

    assign w_instr = instruction_t'(rom_data);

`ifdef CPU_SEQ_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    cpu_cond_eval u_cond_eval (
        .exec (w_instr.exec),
        .flag (r_flag),
        .skip (w_skip)
    );

    assign w_const_dst = is_const_reg(r_ir.write_to);
    assign w_wb_done   = w_const_dst || wr_done;

    // Qualifiers are consumed in FETCH; only set_flag matters afterwards.
    assign w_unused_exec = r_ir.exec.if_flag ^ r_ir.exec.if_not_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:   if (w_go && !w_skip) w_next_state = READ;
            READ:    if (rd_ready)        w_next_state = EXEC;
            EXEC:                         w_next_state = WB;
            WB:      if (w_wb_done)       w_next_state = FETCH;
            default:                      w_next_state = FETCH;
        endcase
    end

    always_comb begin
        rd_en       = 1'b0;
        alu_start   = 1'b0;
        wr_en       = 1'b0;
        w_pc_adv    = 1'b0;
        w_ir_load   = 1'b0;
        w_retire    = 1'b0;
        w_flag_load = 1'b0;
        case (r_state)
            FETCH: begin
                w_pc_adv  = w_go && w_skip;
                w_ir_load = w_go && !w_skip;
            end
            READ:  rd_en     = 1'b1;
            EXEC:  alu_start = 1'b1;
            WB: begin
                wr_en       = !w_const_dst;
                w_pc_adv    = w_wb_done;
                w_retire    = w_wb_done;
                w_flag_load = r_wb_first && r_ir.exec.set_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_flag     <= 1'b0;
            r_wb_first <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_wb_first <= (r_state == EXEC);
            if (w_ir_load) begin
                r_ir <= w_instr;
            end
            if (w_pc_adv) begin
                r_pc <= (r_pc == PCW'(ROM_SIZE - 1)) ? '0 : r_pc + 1'b1;
            end
            if (w_flag_load) begin
                r_flag <= alu_flag;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign rom_addr = r_pc;
    assign rd_sel   = r_ir.r;
    assign wr_sel   = r_ir.write_to;
    assign alu_op   = r_ir.op;
    assign flag     = r_flag;
    assign retired  = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
//==============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Scoreboard bench for cpu_sequencer with directed ROM programs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_sequencer;

    // Encodings: exec {if_flag, if_not_flag, set_flag}; op MOV/ADD/XOR/AND = 0..3
    // registers RA,R0,R1,R2,P0,P1,V0,V1 = 0..7
    localparam logic [10:0] FILLER = 11'b110_00_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rom_addr;
    logic [10:0] rom_data;
    logic [2:0]  rd_sel;
    logic        rd_en;
    logic        rd_ready = 1'b1;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_flag = 1'b0;
    logic [2:0]  wr_sel;
    logic        wr_en;
    logic        wr_done = 1'b1;
    logic        flag;
    logic [7:0]  retired;
`ifdef CPU_SEQ_STEP_EN
    logic        step = 1'b1;
`endif

    logic [10:0] rom [8];
    assign rom_data = rom[rom_addr];

    typedef struct packed {
        logic [2:0] pc;
        logic [1:0] op;
        logic [2:0] rs;
        logic [2:0] ws;
        logic [7:0] ret;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CPU_SEQ_STEP_EN
        .step      (step),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rd_sel    (rd_sel),
        .rd_en     (rd_en),
        .rd_ready  (rd_ready),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_flag  (alu_flag),
        .wr_sel    (wr_sel),
        .wr_en     (wr_en),
        .wr_done   (wr_done),
        .flag      (flag),
        .retired   (retired)
    );

    function automatic logic [10:0] mk(input logic [2:0] ex, input logic [1:0] op,
                                       input logic [2:0] r, input logic [2:0] w);
        return {ex, op, r, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [10:0] v);
        for (int i = 0; i < 8; i++) rom[i] = v;
    endtask

    task automatic push(input int pc, input int op, input int rs, input int ws, input int ret);
        exp_q.push_back({3'(pc), 2'(op), 3'(rs), 3'(ws), 8'(ret)});
    endtask

    // Returns on the negedge where rst drops; the next negedge is cycle c=0.
    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every alu_start must match the next queued instruction issue.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (rd_en && wr_en) begin
                n_errors++;
                $display("FAIL rd_wr_overlap: got rd_en=%b wr_en=%b expected not both", rd_en, wr_en);
            end
            if (alu_start) begin
                mon_act = {rom_addr, alu_op, rd_sel, wr_sel, retired};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected_alu_start: got %h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_errors++;
                        $display("FAIL sb_issue: got pc/op/rs/ws/ret=%h expected %h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state and continuous run of MOV V1 -> RA
        fill_rom(mk(3'b000, 2'd0, 3'd7, 3'd0));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pc", rom_addr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_flag", flag, 0);
        chk("rst_retired", retired, 0);
        for (int i = 0; i < 8; i++) push(i, 0, 7, 0, i);
        rst = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("t1_alu_start", alu_start, (c % 4 == 1) ? 1 : 0);
            chk("t1_rd_en", rd_en, (c % 4 == 0) ? 1 : 0);
            if (c == 27) chk("t1_pc_last", rom_addr, 7);
        end
        chk("t1_retired", retired, 8);
        chk("t1_pc_wrap", rom_addr, 0);

        // Read stall on P1
        fill_rom(FILLER);
        rom[0] = mk(3'b000, 2'd0, 3'd5, 3'd1);
        rd_ready = 1'b0;
        push(0, 0, 5, 1, 0);
        reset_dut();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t2_rd_en", rd_en, 1);
            chk("t2_rd_sel", rd_sel, 5);
            chk("t2_no_start", alu_start, 0);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        chk("t2_alu_start", alu_start, 1);
        chk("t2_rd_en_drop", rd_en, 0);
        @(negedge clk);
        chk("t2_wr_en", wr_en, 1);
        chk("t2_wr_sel", wr_sel, 1);
        @(negedge clk);
        chk("t2_retired", retired, 1);

        // Flag set, if_not_flag skipped, if_flag executed
        fill_rom(FILLER);
        rom[0] = mk(3'b001, 2'd2, 3'd2, 3'd3);
        rom[1] = mk(3'b010, 2'd1, 3'd1, 3'd0);
        rom[2] = mk(3'b100, 2'd3, 3'd4, 3'd5);
        alu_flag = 1'b1;
        push(0, 2, 2, 3, 0);
        push(2, 3, 4, 5, 1);
        reset_dut();
        repeat (4) @(negedge clk);
        chk("t3_flag_set", flag, 1);
        chk("t3_pc1", rom_addr, 1);
        @(negedge clk);
        chk("t3_skip_pc", rom_addr, 2);
        chk("t3_skip_rd_en", rd_en, 0);
        @(negedge clk);
        chk("t3_exec_rd_en", rd_en, 1);
        repeat (3) @(negedge clk);
        chk("t3_retired", retired, 2);
        chk("t3_flag_kept", flag, 1);

        // Constant destination V0: no write strobe, single WB cycle
        fill_rom(FILLER);
        rom[0] = mk(3'b000, 2'd0, 3'd1, 3'd6);
        alu_flag = 1'b0;
        wr_done  = 1'b0;
        push(0, 0, 1, 6, 0);
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_wr_en", wr_en, 0);
        end
        @(negedge clk);
        chk("t4_retired", retired, 1);
        chk("t4_pc", rom_addr, 1);
        wr_done = 1'b1;

        // Both qualifiers set: skipped with flag 0 and with flag 1
        fill_rom(FILLER);
        rom[1] = mk(3'b001, 2'd2, 3'd1, 3'd7);
        alu_flag = 1'b1;
        push(1, 2, 1, 7, 0);
        reset_dut();
        @(negedge clk);
        chk("t5_skip0_pc", rom_addr, 1);
        chk("t5_skip0_rd_en", rd_en, 0);
        repeat (4) @(negedge clk);
        chk("t5_flag", flag, 1);
        chk("t5_pc2", rom_addr, 2);
        @(negedge clk);
        chk("t5_skip1_pc", rom_addr, 3);
        chk("t5_skip1_rd_en", rd_en, 0);
        chk("t5_retired", retired, 1);

        // Reset in WB while write is stalled
        fill_rom(FILLER);
        rom[0] = mk(3'b001, 2'd2, 3'd1, 3'd2);
        wr_done = 1'b0;
        push(0, 2, 1, 2, 0);
        reset_dut();
        repeat (4) @(negedge clk);
        chk("t6_wb_wr_en", wr_en, 1);
        chk("t6_flag_pre", flag, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_pc", rom_addr, 0);
        chk("t6_wr_en", wr_en, 0);
        chk("t6_rd_en", rd_en, 0);
        chk("t6_flag", flag, 0);
        chk("t6_retired", retired, 0);
        wr_done = 1'b1;

`ifdef CPU_SEQ_STEP_EN
        // Step low freezes FETCH; one pulse issues one instruction
        fill_rom(mk(3'b000, 2'd0, 3'd7, 3'd0));
        step = 1'b0;
        reset_dut();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("st_hold_pc", rom_addr, 0);
            chk("st_hold_rd_en", rd_en, 0);
        end
        push(0, 0, 7, 0, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        chk("st_retired", retired, 1);
        chk("st_pc", rom_addr, 1);
        chk("st_idle", rd_en, 0);
        step = 1'b1;
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit mini CPU.
- Fetches each 11-bit instruction from the instruction ROM and evaluates conditional execution against the flag.
- Sequences, per instruction: register read with handshake, ALU start, then register/accumulator writeback with handshake.
- Owns the PC, the instruction register and the condition flag. The datapath (acc, register file, ports, ALU) stays external and is driven only through strobes and selects.

Parameters:
- ROM_SIZE, 8, instruction ROM depth. PC width is PCW = $clog2(ROM_SIZE).
- WORD_SIZE, 8, datapath word width. Used only for the retired-instruction counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rom_addr  out  PCW  current PC, drives the ROM address
- rom_data  in  11  instruction at rom_addr, combinational: {exec[2:0], op[1:0], r[2:0], write_to[2:0]}
- rd_sel  out  3  register_name of the ALU b operand (ir.r)
- rd_en  out  1  read request
- rd_ready  in  1  read data valid (ports may stall)
- alu_op  out  2  alu_op from ir.op
- alu_start  out  1  one-cycle ALU launch
- alu_flag  in  1  ALU flag output
- wr_sel  out  3  destination register_name (ir.write_to)
- wr_en  out  1  write request
- wr_done  in  1  write accepted
- flag  out  1  current condition flag
- retired  out  WORD_SIZE  count of executed (non-skipped) instructions, wraps

Behaviour:
- Reset values: state FETCH, pc 0, ir 0, flag 0, retired 0; rd_en, alu_start, wr_en all 0.
- rst mid-instruction: the instruction is aborted; no write strobe is issued in the next cycle.
- States: FETCH, READ, EXEC, WB.
- FETCH: evaluates rom_data.exec against flag.
  - if_flag=1 requires flag=1; if_not_flag=1 requires flag=0; both set means never execute.
  - Skip: pc <= pc+1 and stay in FETCH. A skipped instruction costs 1 cycle.
  - Execute: ir <= rom_data, go to READ.
- READ: rd_en=1 and rd_sel=ir.r, held stable until rd_ready=1.
  - Leave on the first cycle rd_ready=1 and go to EXEC.
  - rd_ready may be high in the first READ cycle (V0/V1/RA/R1), giving zero stall.
- EXEC: alu_start=1 for exactly one cycle; alu_op is valid throughout READ/EXEC/WB. Go to WB.
- WB: if ir.set_flag, flag <= alu_flag, captured in the first WB cycle only.
  - write_to V0 or V1 (constants): no wr_en; complete in 1 cycle.
  - Otherwise wr_en=1 and wr_sel=ir.write_to, held until wr_done=1.
  - On completion: pc <= pc+1, retired <= retired+1, go to FETCH.
- Minimum latency per executed instruction: 4 cycles (FETCH, READ, EXEC, WB) plus port stalls. No upper bound on stalls.
- PC wraps from ROM_SIZE-1 to 0 with no halt.
- alu_op, rd_sel and wr_sel are driven from ir. They are don't-care in FETCH, but rd_en and wr_en must be 0 there.
- rd_en and wr_en are never high in the same cycle.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- Defined: adds input step (1 bit). FETCH only evaluates or advances on cycles where step=1, otherwise it holds.
  - Exactly one instruction, executed or skipped, is issued per step pulse.
  - A step held high counts as continuous run.
- Undefined: no step port; FETCH proceeds every cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - word, alu_op, register_name, exec_opts and the instruction struct.
  - The state enum cpu_seq_state {FETCH, READ, EXEC, WB}.
  - Constants ROM_SIZE and WORD_SIZE defaults.
- Natural sub-module: cpu_cond_eval, combinational skip decision from (exec_opts, flag).
- Everything else stays in cpu_sequencer.

Test Plan:
- Reset, then ROM all unconditional MOV r=V1 write_to=RA, with rd_ready and wr_done tied high.
  - Required: new instruction every 4 cycles; pc 0→7→0 wraps; retired=8 after 32 cycles; exactly one alu_start per instruction.
- Port stall: instruction r=P1 with rd_ready held low 5 cycles.
  - Required: rd_en high for 6 cycles with rd_sel=P1 stable; alu_start in the cycle after rd_ready rises.
- Flag/conditional: XOR with set_flag and alu_flag=1, then if_not_flag instr, then if_flag instr.
  - Required: second skipped in 1 cycle (pc advances, no rd_en); third executes; retired increments by 2.
- Constant destination: write_to=V0.
  - Required: wr_en never asserted; WB lasts 1 cycle; retired increments.
- Both if_flag and if_not_flag set, with flag 0 and flag 1.
  - Required: always skipped.
- rst asserted during WB with wr_done low.
  - Required: next cycle state FETCH, pc 0, wr_en 0, flag 0, retired 0.
- (CPU_SEQ_STEP_EN) step low.
  - Required: pc and state frozen in FETCH.
- (CPU_SEQ_STEP_EN) single step pulse.
  - Required: exactly one instruction completes.
